// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl_if : hazard/stall request and control bundle for pipe_ctrl       |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
interface pipe_ctrl_if #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
);
    logic                stallreq_if;
    logic                id_reg1_read;
    logic [4:0]          id_reg1_addr;
    logic                id_reg2_read;
    logic [4:0]          id_reg2_addr;
    logic                ex_is_load;
    logic                ex_wreg;
    logic [4:0]          ex_wd;
    logic                ex_mc_start;
    logic [MC_CNT_W-1:0] ex_mc_cycles;
    logic                flush_req;
    logic [31:0]         flush_pc;
    logic                perf_clr;
    logic [5:0]          stall;
    logic                flush;
    logic [31:0]         new_pc;
    logic                mc_busy;
    logic [PERF_W-1:0]   stall_cycles;

    modport master (
        output stallreq_if, id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
        output ex_is_load, ex_wreg, ex_wd, ex_mc_start, ex_mc_cycles,
        output flush_req, flush_pc, perf_clr,
        input  stall, flush, new_pc, mc_busy, stall_cycles
    );

    modport slave (
        input  stallreq_if, id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
        input  ex_is_load, ex_wreg, ex_wd, ex_mc_start, ex_mc_cycles,
        input  flush_req, flush_pc, perf_clr,
        output stall, flush, new_pc, mc_busy, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl : five-stage pipeline stall/flush control with multi-cycle EX    |
// |             sequencing and a saturating stall-cycle counter                |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module pipe_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    localparam logic [5:0]          C_STALL_NONE = 6'b000000;
    localparam logic [5:0]          C_STALL_MC   = 6'b001111;
    localparam logic [5:0]          C_STALL_LU   = 6'b000111;
    localparam logic [5:0]          C_STALL_IF   = 6'b000011;
    localparam logic [MC_CNT_W-1:0] C_MC_ONE     = {{(MC_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0]   C_PERF_ONE   = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0]   C_PERF_MAX   = {PERF_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MC  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MC_CNT_W-1:0] r_mc_cnt;
    logic [MC_CNT_W-1:0] w_mc_cnt_nxt;
    logic [PERF_W-1:0]   r_stall_cycles;
    logic [5:0]          w_stall;
    logic                w_flush;
    logic [31:0]         w_new_pc;
    logic                w_load_use;
    logic                w_mc_start;

    assign w_load_use = bus.ex_is_load && bus.ex_wreg && (bus.ex_wd != 5'd0) &&
                        ((bus.id_reg1_read && (bus.id_reg1_addr == bus.ex_wd)) ||
                         (bus.id_reg2_read && (bus.id_reg2_addr == bus.ex_wd)));

    // A zero-length request is treated as no request at all.
    assign w_mc_start = bus.ex_mc_start && (bus.ex_mc_cycles != '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;
        w_stall      = C_STALL_NONE;
        w_flush      = 1'b0;
        w_new_pc     = 32'd0;
        if (!rst) begin
            w_state_nxt  = ST_RUN;
            w_mc_cnt_nxt = '0;
        end else if (bus.flush_req) begin
            w_flush      = 1'b1;
            w_new_pc     = bus.flush_pc;
            w_state_nxt  = ST_RUN;
            w_mc_cnt_nxt = '0;
        end else if (r_state == ST_MC) begin
            w_stall      = C_STALL_MC;
            w_mc_cnt_nxt = r_mc_cnt - C_MC_ONE;
            if (r_mc_cnt == C_MC_ONE) begin
                w_state_nxt = ST_RUN;
            end
        end else if (w_mc_start) begin
            // The start cycle itself is the first of the N stalled cycles.
            w_stall = C_STALL_MC;
            if (bus.ex_mc_cycles > C_MC_ONE) begin
                w_state_nxt  = ST_MC;
                w_mc_cnt_nxt = bus.ex_mc_cycles - C_MC_ONE;
            end
        end else if (w_load_use) begin
            w_stall = C_STALL_LU;
        end else if (bus.stallreq_if) begin
            w_stall = C_STALL_IF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (bus.perf_clr) begin
            r_stall_cycles <= '0;
        end else if (w_stall[0] && (r_stall_cycles != C_PERF_MAX)) begin
            r_stall_cycles <= r_stall_cycles + C_PERF_ONE;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.new_pc       = w_new_pc;
    assign bus.mc_busy      = (r_state == ST_MC);
    assign bus.stall_cycles = r_stall_cycles;
endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_ctrl : directed self-checking bench for pipe_ctrl                  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.MC_CNT_W(6), .PERF_W(32)) bus ();
    pipe_ctrl_if #(.MC_CNT_W(6), .PERF_W(4))  bus_s ();

    pipe_ctrl #(.MC_CNT_W(6), .PERF_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    pipe_ctrl #(.MC_CNT_W(6), .PERF_W(4))  u_small (.clk(clk), .rst(rst), .bus(bus_s));

    task automatic clear_inputs();
        bus.stallreq_if = 0; bus.id_reg1_read = 0; bus.id_reg1_addr = 0;
        bus.id_reg2_read = 0; bus.id_reg2_addr = 0; bus.ex_is_load = 0;
        bus.ex_wreg = 0; bus.ex_wd = 0; bus.ex_mc_start = 0; bus.ex_mc_cycles = 0;
        bus.flush_req = 0; bus.flush_pc = 0; bus.perf_clr = 0;
        bus_s.stallreq_if = 0; bus_s.id_reg1_read = 0; bus_s.id_reg1_addr = 0;
        bus_s.id_reg2_read = 0; bus_s.id_reg2_addr = 0; bus_s.ex_is_load = 0;
        bus_s.ex_wreg = 0; bus_s.ex_wd = 0; bus_s.ex_mc_start = 0; bus_s.ex_mc_cycles = 0;
        bus_s.flush_req = 0; bus_s.flush_pc = 0; bus_s.perf_clr = 0;
    endtask

    // Next cycle: clear inputs, pulse perf_clr so the main counter starts at 0.
    task automatic zero_counter();
        @(posedge clk); #1; clear_inputs(); bus.perf_clr = 1;
        @(posedge clk); #1; bus.perf_clr = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0; bus.stallreq_if = 1; bus.flush_req = 1; bus.flush_pc = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL reset_stall got %b exp %b", bus.stall, 6'b0); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
        checks++; if (bus.new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", bus.new_pc); end
        checks++; if (bus.stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_stall_cycles got %0d exp 0", bus.stall_cycles); end
        checks++; if (bus.mc_busy !== 1'b0) begin errors++; $display("FAIL reset_mc_busy got %b exp 0", bus.mc_busy); end
        clear_inputs();
        @(posedge clk); #1; rst = 1;
        repeat (2) begin
            @(posedge clk); #2;
            checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL post_reset_stall got %b exp %b", bus.stall, 6'b0); end
        end
        checks++; if (bus.stall_cycles !== 32'h0) begin errors++; $display("FAIL post_reset_count got %0d exp 0", bus.stall_cycles); end
    endtask

    task automatic test_load_use();
        zero_counter();
        bus.ex_is_load = 1; bus.ex_wreg = 1; bus.ex_wd = 5'd5; bus.id_reg2_read = 1; bus.id_reg2_addr = 5'd5;
        #1;
        checks++; if (bus.stall !== 6'b000111) begin errors++; $display("FAIL lu_reg2 got %b exp %b", bus.stall, 6'b000111); end
        @(posedge clk); #1; clear_inputs(); #1;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL lu_after got %b exp %b", bus.stall, 6'b0); end
        checks++; if (bus.stall_cycles !== 32'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", bus.stall_cycles); end
        bus.ex_is_load = 1; bus.ex_wreg = 1; bus.ex_wd = 5'd0; bus.id_reg2_read = 1; bus.id_reg2_addr = 5'd0;
        #1;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL lu_r0 got %b exp %b", bus.stall, 6'b0); end
        bus.ex_wd = 5'd7; bus.id_reg2_read = 0; bus.id_reg1_read = 1; bus.id_reg1_addr = 5'd7;
        #1;
        checks++; if (bus.stall !== 6'b000111) begin errors++; $display("FAIL lu_reg1 got %b exp %b", bus.stall, 6'b000111); end
        bus.id_reg1_read = 0;
        #1;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL lu_noread got %b exp %b", bus.stall, 6'b0); end
        bus.id_reg1_read = 1; bus.ex_wreg = 0;
        #1;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL lu_nowreg got %b exp %b", bus.stall, 6'b0); end
        bus.ex_wreg = 1; bus.ex_is_load = 0;
        #1;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL lu_noload got %b exp %b", bus.stall, 6'b0); end
        clear_inputs();
    endtask

    task automatic test_multi_cycle();
        zero_counter();
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 6'd4;
        #1;
        checks++; if (bus.stall !== 6'b001111) begin errors++; $display("FAIL mc4_c1_stall got %b exp %b", bus.stall, 6'b001111); end
        checks++; if (bus.mc_busy !== 1'b0) begin errors++; $display("FAIL mc4_c1_busy got %b exp 0", bus.mc_busy); end
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk); #1; clear_inputs(); #1;
            checks++; if (bus.stall !== 6'b001111) begin errors++; $display("FAIL mc4_c%0d_stall got %b exp %b", c, bus.stall, 6'b001111); end
            checks++; if (bus.mc_busy !== 1'b1) begin errors++; $display("FAIL mc4_c%0d_busy got %b exp 1", c, bus.mc_busy); end
        end
        @(posedge clk); #2;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL mc4_exit_stall got %b exp %b", bus.stall, 6'b0); end
        checks++; if (bus.mc_busy !== 1'b0) begin errors++; $display("FAIL mc4_exit_busy got %b exp 0", bus.mc_busy); end
        checks++; if (bus.stall_cycles !== 32'd4) begin errors++; $display("FAIL mc4_count got %0d exp 4", bus.stall_cycles); end
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 6'd1;
        #1;
        checks++; if (bus.stall !== 6'b001111) begin errors++; $display("FAIL mc1_stall got %b exp %b", bus.stall, 6'b001111); end
        @(posedge clk); #1; clear_inputs(); #1;
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL mc1_after got %b exp %b", bus.stall, 6'b0); end
        checks++; if (bus.mc_busy !== 1'b0) begin errors++; $display("FAIL mc1_busy got %b exp 0", bus.mc_busy); end
        checks++; if (bus.stall_cycles !== 32'd5) begin errors++; $display("FAIL mc1_count got %0d exp 5", bus.stall_cycles); end
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 6'd0; bus.stallreq_if = 1;
        #1;
        checks++; if (bus.stall !== 6'b000011) begin errors++; $display("FAIL mc0_fallthru got %b exp %b", bus.stall, 6'b000011); end
        @(posedge clk); #1; clear_inputs(); #1;
        checks++; if (bus.mc_busy !== 1'b0) begin errors++; $display("FAIL mc0_busy got %b exp 0", bus.mc_busy); end
    endtask

    task automatic test_flush_abort();
        @(posedge clk); #1; clear_inputs();
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 6'd10;
        @(posedge clk); #1; clear_inputs(); #1;
        checks++; if (bus.mc_busy !== 1'b1) begin errors++; $display("FAIL fl_c2_busy got %b exp 1", bus.mc_busy); end
        @(posedge clk); #1; bus.flush_req = 1; bus.flush_pc = 32'hBFC0_0380; #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL fl_flush got %b exp 1", bus.flush); end
        checks++; if (bus.new_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL fl_new_pc got %h exp %h", bus.new_pc, 32'hBFC0_0380); end
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL fl_stall got %b exp %b", bus.stall, 6'b0); end
        @(posedge clk); #1; clear_inputs(); #1;
        checks++; if (bus.mc_busy !== 1'b0) begin errors++; $display("FAIL fl_next_busy got %b exp 0", bus.mc_busy); end
        checks++; if (bus.stall !== 6'b0) begin errors++; $display("FAIL fl_next_stall got %b exp %b", bus.stall, 6'b0); end
        checks++; if (bus.flush !== 1'b0 || bus.new_pc !== 32'h0) begin errors++; $display("FAIL fl_next_flush got %b/%h exp 0/0", bus.flush, bus.new_pc); end
    endtask

    task automatic test_priority();
        @(posedge clk); #1; clear_inputs();
        bus.stallreq_if = 1; #1;
        checks++; if (bus.stall !== 6'b000011) begin errors++; $display("FAIL pr_if_only got %b exp %b", bus.stall, 6'b000011); end
        bus.ex_is_load = 1; bus.ex_wreg = 1; bus.ex_wd = 5'd9; bus.id_reg1_read = 1; bus.id_reg1_addr = 5'd9; #1;
        checks++; if (bus.stall !== 6'b000111) begin errors++; $display("FAIL pr_lu_over_if got %b exp %b", bus.stall, 6'b000111); end
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 6'd2; #1;
        checks++; if (bus.stall !== 6'b001111) begin errors++; $display("FAIL pr_mc_over_lu got %b exp %b", bus.stall, 6'b001111); end
        @(posedge clk); #1; bus.ex_mc_cycles = 6'd5; #1;
        checks++; if (bus.stall !== 6'b001111 || bus.mc_busy !== 1'b1) begin errors++; $display("FAIL pr_mc2_c2 got %b/%b exp %b/1", bus.stall, bus.mc_busy, 6'b001111); end
        @(posedge clk); #1; clear_inputs(); #1;
        checks++; if (bus.stall !== 6'b0 || bus.mc_busy !== 1'b0) begin errors++; $display("FAIL pr_mc2_exit got %b/%b exp %b/0", bus.stall, bus.mc_busy, 6'b0); end
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 6'd3; bus.flush_req = 1; bus.flush_pc = 32'h8000_0180; #1;
        checks++; if (bus.stall !== 6'b0 || bus.flush !== 1'b1) begin errors++; $display("FAIL pr_flush_over_mc got %b/%b exp %b/1", bus.stall, bus.flush, 6'b0); end
        @(posedge clk); #1; clear_inputs(); #1;
        checks++; if (bus.mc_busy !== 1'b0) begin errors++; $display("FAIL pr_flush_no_mc got %b exp 0", bus.mc_busy); end
    endtask

    task automatic test_reset_mid_mc();
        @(posedge clk); #1; clear_inputs();
        bus.ex_mc_start = 1; bus.ex_mc_cycles = 6'd10;
        @(posedge clk); #1; clear_inputs(); #1;
        checks++; if (bus.mc_busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got %b exp 1", bus.mc_busy); end
        rst = 0; #1;
        checks++; if (bus.mc_busy !== 1'b0 || bus.stall !== 6'b0) begin errors++; $display("FAIL rm_async got %b/%b exp 0/%b", bus.mc_busy, bus.stall, 6'b0); end
        checks++; if (bus.stall_cycles !== 32'h0) begin errors++; $display("FAIL rm_count got %0d exp 0", bus.stall_cycles); end
        @(posedge clk); #1; rst = 1;
        repeat (2) begin
            @(posedge clk); #2;
            checks++; if (bus.mc_busy !== 1'b0 || bus.stall !== 6'b0) begin errors++; $display("FAIL rm_after got %b/%b exp 0/%b", bus.mc_busy, bus.stall, 6'b0); end
        end
    endtask

    task automatic test_counter();
        @(posedge clk); #1; clear_inputs(); bus_s.perf_clr = 1;
        @(posedge clk); #1; bus_s.perf_clr = 0; bus_s.stallreq_if = 1; #1;
        checks++; if (bus_s.stall !== 6'b000011) begin errors++; $display("FAIL sat_stall got %b exp %b", bus_s.stall, 6'b000011); end
        repeat (14) @(posedge clk);
        #1;
        checks++; if (bus_s.stall_cycles !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d exp 14", bus_s.stall_cycles); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (bus_s.stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", bus_s.stall_cycles); end
        bus_s.perf_clr = 1;
        @(posedge clk); #1;
        checks++; if (bus_s.stall_cycles !== 4'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", bus_s.stall_cycles); end
        bus_s.perf_clr = 0;
        @(posedge clk); #1;
        checks++; if (bus_s.stall_cycles !== 4'd1) begin errors++; $display("FAIL sat_restart got %0d exp 1", bus_s.stall_cycles); end
        bus_s.stallreq_if = 0;
        @(posedge clk); #1;
        checks++; if (bus_s.stall_cycles !== 4'd1) begin errors++; $display("FAIL sat_idle got %0d exp 1", bus_s.stall_cycles); end
        bus.stallreq_if = 1;
        repeat (3) @(posedge clk);
        #1; bus.perf_clr = 1;
        @(posedge clk); #1; bus.perf_clr = 0; bus.stallreq_if = 0;
        checks++; if (bus.stall_cycles !== 32'd0) begin errors++; $display("FAIL main_clr got %0d exp 0", bus.stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_flush_abort();
        test_priority();
        test_reset_mid_mc();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control unit for the five-stage CPU. It produces the 6-bit stall vector that every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb) consumes, and the flush/new-PC pair used on exceptions. It detects load-use hazards between ID and EX, arbitrates stall requests from IF and EX, and sequences multi-cycle EX operations (mult-accumulate, divide) with an internal down-counter. It also keeps a saturating stall-cycle performance counter.

## Interface
- MC_CNT_W, 6, width of the multi-cycle length field and internal counter
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-low
- stallreq_if  in  1  fetch not ready (instruction-side wait)
- id_reg1_read  in  1  ID reads operand 1 from the register file
- id_reg1_addr  in  5  ID operand 1 register address
- id_reg2_read  in  1  ID reads operand 2 from the register file
- id_reg2_addr  in  5  ID operand 2 register address
- ex_is_load  in  1  instruction in EX is a load
- ex_wreg  in  1  instruction in EX writes a register
- ex_wd  in  5  EX destination register
- ex_mc_start  in  1  first EX cycle of a multi-cycle operation
- ex_mc_cycles  in  MC_CNT_W  number of stall cycles N the operation needs
- flush_req  in  1  exception taken in MEM
- flush_pc  in  32  handler address
- perf_clr  in  1  synchronous clear of stall_cycles
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage
- flush  out  1  kill all in-flight instructions this cycle
- new_pc  out  32  PC to load when flush=1, else 0
- mc_busy  out  1  high while in state MC
- stall_cycles  out  32  count of cycles with stall[0]=1, saturating

## Operation
- States: RUN, MC. Registered: state, mc_cnt[MC_CNT_W-1:0], stall_cycles.
- stall, flush, new_pc are combinational from the current inputs and the registered state. Per-cycle priority, highest first:
  - flush_req=1: flush=1, new_pc=flush_pc, stall=6'b000000. Next state RUN, mc_cnt<=0 (this aborts an active MC).
  - State MC: stall=6'b001111. mc_cnt<=mc_cnt-1. If mc_cnt==1, next state RUN.
  - RUN with ex_mc_start=1 and ex_mc_cycles=N>=1: stall=6'b001111. If N>1, go to MC with mc_cnt<=N-1; if N==1, stay in RUN. N=0: ex_mc_start is ignored and evaluation falls through.
  - Load-use: ex_is_load and ex_wreg and ex_wd!=0 and ((id_reg1_read and id_reg1_addr==ex_wd) or (id_reg2_read and id_reg2_addr==ex_wd)) gives stall=6'b000111. The bubble is inserted by id_ex (stall[2]=1, stall[3]=0).
  - stallreq_if=1: stall=6'b000011. The bubble is inserted by if_id.
  - Otherwise stall=0, flush=0, new_pc=0.
- ex_mc_start is ignored while in MC, because EX re-presents the same instruction while frozen.
- The total EX stall for an operation with length N is exactly N cycles. EX advances on the cycle after the last stalled cycle.
- stall_cycles: +1 at each posedge where stall[0]=1, and it holds at 32'hFFFFFFFF. If perf_clr=1 the counter loads 0, and this takes precedence over increment.
- mc_busy = (state==MC).

## Timing
- rst=0 (asynchronous, any time): state=RUN, mc_cnt=0, stall_cycles=0. While rst=0, outputs are forced to stall=0, flush=0, new_pc=0, mc_busy=0.
- Deasserting rst mid-MC means the next operation starts from RUN. No stall persists past reset.
- Outputs are valid in the same cycle as the request (zero latency), so stage registers sample the vector at the next posedge.
- MC entry takes effect at the posedge ending the start cycle, and MC exit at the posedge where mc_cnt==1.
- Simultaneous requests resolve by the priority list above. Lower requests are not queued; they are re-evaluated every cycle.
- mc_cnt arithmetic is unsigned MC_CNT_W bits. The maximum is N=2^MC_CNT_W-1. There is no wrap, because decrement never occurs at 0.

## Test plan
- Reset: hold rst=0 with stallreq_if=1 and flush_req=1. Required: stall=0, flush=0, new_pc=0, stall_cycles=0. Release rst with no requests: stall stays 0.
- Load-use: ex_is_load=1, ex_wreg=1, ex_wd=5, id_reg2_read=1, id_reg2_addr=5 for one cycle. Required: stall=000111 in that cycle only. Repeat with ex_wd=0: stall=0.
- Multi-cycle: ex_mc_start=1 with N=4 for one cycle. Required: stall=001111 for exactly 4 cycles, mc_busy high for cycles 2-4, stall_cycles +4. With N=1: one stall cycle and mc_busy never asserts.
- Flush abort: start N=10, then assert flush_req with flush_pc=0xBFC00380 on the 3rd cycle. Required: in that cycle flush=1, new_pc=0xBFC00380, stall=0. Next cycle: state RUN, mc_busy=0.
- Priority: stallreq_if=1 plus the load-use condition together gives 000111. Adding ex_mc_start with N=2 gives 001111.
- Counter: preload near saturation by running long stalls, or use a reduced-width test build. Required: stall_cycles holds at max, and perf_clr together with stall gives 0 at the next edge.
